oflow_fsm_write: RTL and testbench

Write-side controller for the oflow history frame buffer. It accepts the bounding boxes of the current frame from the upstream detection interface, packs them two per memory line, and drives the buffer write port. At end of frame it publishes the per-slot bbox count in `end_pointers`, which the downstream read FSM consumes. Slots are used round-robin across the five history frames.

---
 rtl/oflow_buffer_pkg.sv | 29 ++
 rtl/oflow_fsm_write_if.sv | 27 ++
 rtl/oflow_slot_counter.sv | 21 ++
 rtl/oflow_fsm_write.sv | 126 ++++++++++++
 tb/tb_oflow_fsm_write.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/oflow_buffer_pkg.sv
// Shared definitions for the oflow history frame buffer controllers
// (write FSM and read FSM): state encoding, slot count, widths, slot wrap.
package oflow_buffer_pkg;

    localparam int NUM_SLOTS  = 5;
    localparam int SLOT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } write_state_t;

    // An end pointer must hold a full-frame count of 2**(addr_width+1).
    function automatic int ep_width(input int addr_width);
        return addr_width + 2;
    endfunction

    // Round-robin successor of a slot index.
    function automatic logic [SLOT_WIDTH-1:0] slot_next(
        input logic [SLOT_WIDTH-1:0] slot,
        input int                    num_slots
    );
        if (int'(slot) == num_slots - 1)
            return '0;
        return slot + 1'b1;
    endfunction

endpackage

// File: rtl/oflow_fsm_write_if.sv
// Bus bundles of the oflow write controller: the upstream bbox stream
// (valid/ready handshake) and the frame buffer write port.
interface oflow_bbox_if #(
    parameter int BBOX_WIDTH = 64
);
    logic                  bbox_valid;
    logic                  bbox_last;
    logic [BBOX_WIDTH-1:0] bbox_in;
    logic                  bbox_ready;

    modport master (output bbox_valid, bbox_last, bbox_in, input  bbox_ready);
    modport slave  (input  bbox_valid, bbox_last, bbox_in, output bbox_ready);
endinterface

interface oflow_wr_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int BBOX_WIDTH = 64
);
    logic                  we;
    logic [2:0]            wr_slot;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_offset;
    logic [BBOX_WIDTH-1:0] wr_data;

    modport master (output we, wr_slot, wr_addr, wr_offset, wr_data);
    modport slave  (input  we, wr_slot, wr_addr, wr_offset, wr_data);
endinterface

// File: rtl/oflow_slot_counter.sv
// Round-robin history slot counter; steps one slot per advance pulse and
// wraps after NUM_SLOTS-1. Shared by the write and read controllers.
module oflow_slot_counter #(
    parameter int NUM_SLOTS = 5
) (
    input  logic                                clk,
    input  logic                                reset_N,
    input  logic                                advance,
    output logic [oflow_buffer_pkg::SLOT_WIDTH-1:0] slot
);
    import oflow_buffer_pkg::*;

    // Slot register: cleared by reset, moves on at each end of frame.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N)
            slot <= '0;
        else if (advance)
            slot <= slot_next(slot, NUM_SLOTS);
    end

endmodule

// File: rtl/oflow_fsm_write.sv
// oflow write controller: takes one frame of bboxes, packs them two per
// buffer line into the current history slot, and publishes the per-slot
// bbox count in end_pointers when the frame ends. Bboxes beyond the frame
// capacity are dropped and flagged through the sticky overflow output.
// Optional OFLOW_WRITE_DROP_CNT_EN adds a saturating drop_cnt output.
module oflow_fsm_write #(
    parameter int ADDR_WIDTH      = 5,
    parameter int BBOX_WIDTH      = 64,
    parameter int NUM_SLOTS       = oflow_buffer_pkg::NUM_SLOTS,
    parameter int FRAME_NUM_WIDTH = 8,
    localparam int EP_WIDTH       = oflow_buffer_pkg::ep_width(ADDR_WIDTH)
) (
    input  logic                               clk,
    input  logic                               reset_N,
    input  logic                               start_write,
    input  logic [FRAME_NUM_WIDTH-1:0]         frame_num,
    oflow_bbox_if.slave                        bbox,
    oflow_wr_if.master                         wr,
    output logic [NUM_SLOTS-1:0][EP_WIDTH-1:0] end_pointers,
    output logic [FRAME_NUM_WIDTH-1:0]         cur_frame_num,
    output logic                               done_write,
    output logic                               overflow
`ifdef OFLOW_WRITE_DROP_CNT_EN
    ,
    output logic [EP_WIDTH-1:0]                drop_cnt
`endif
);
    import oflow_buffer_pkg::*;

    // Frame capacity in bboxes: two per line.
    localparam logic [EP_WIDTH-1:0] CAP = EP_WIDTH'(2 ** (ADDR_WIDTH + 1));

    write_state_t          state;
    logic [EP_WIDTH-1:0]   bbox_cnt;
    logic [SLOT_WIDTH-1:0] slot;
    logic                  accept;
    logic                  slot_adv;

    // bbox_ready is a registered copy of "state == WRITE", so a handshake
    // can only complete while writing.
    assign accept   = bbox.bbox_valid && bbox.bbox_ready;
    assign slot_adv = (state == DONE);
    assign wr.wr_slot = slot;

    oflow_slot_counter #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slot (
        .clk     (clk),
        .reset_N (reset_N),
        .advance (slot_adv),
        .slot    (slot)
    );

    // Frame FSM with registered handshake, write port and status outputs.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state           <= IDLE;
            bbox_cnt        <= '0;
            end_pointers    <= '0;
            cur_frame_num   <= '0;
            done_write      <= 1'b0;
            overflow        <= 1'b0;
            bbox.bbox_ready <= 1'b0;
            wr.we           <= 1'b0;
            wr.wr_addr      <= '0;
            wr.wr_offset    <= 1'b0;
            wr.wr_data      <= '0;
`ifdef OFLOW_WRITE_DROP_CNT_EN
            drop_cnt        <= '0;
`endif
        end else begin
            // Strobes are single-cycle by default.
            wr.we      <= 1'b0;
            done_write <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_write) begin
                        cur_frame_num      <= frame_num;
                        bbox_cnt           <= '0;
                        overflow           <= 1'b0;
                        end_pointers[slot] <= '0;
                        bbox.bbox_ready    <= 1'b1;
                        state              <= WRITE;
`ifdef OFLOW_WRITE_DROP_CNT_EN
                        drop_cnt           <= '0;
`endif
                    end
                end
                WRITE: begin
                    if (accept) begin
                        if (bbox_cnt == CAP) begin
                            // Frame full: drop the bbox, count stays at CAP.
                            overflow <= 1'b1;
`ifdef OFLOW_WRITE_DROP_CNT_EN
                            if (drop_cnt != '1)
                                drop_cnt <= drop_cnt + 1'b1;
`endif
                        end else begin
                            wr.we        <= 1'b1;
                            wr.wr_addr   <= bbox_cnt[ADDR_WIDTH:1];
                            wr.wr_offset <= bbox_cnt[0];
                            wr.wr_data   <= bbox.bbox_in;
                            bbox_cnt     <= bbox_cnt + 1'b1;
                        end
                        // The frame ends on its last bbox even if it was dropped.
                        if (bbox.bbox_last) begin
                            bbox.bbox_ready <= 1'b0;
                            done_write      <= 1'b1;
                            state           <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Slot advances in the slot counter on this same edge.
                    end_pointers[slot] <= bbox_cnt;
                    state              <= IDLE;
                end
                default: begin
                    bbox.bbox_ready <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oflow_fsm_write.sv
// Directed bench for oflow_fsm_write: a full-size instance (ADDR_WIDTH=5)
// and a small one (ADDR_WIDTH=2, capacity 8) fed the same bbox stream.
`timescale 1ns/1ps
module tb_oflow_fsm_write;
    localparam int AW   = 5;
    localparam int AWS  = 2;
    localparam int BW   = 64;
    localparam int NS   = 5;
    localparam int FW   = 8;
    localparam int EPW  = AW + 2;
    localparam int EPWS = AWS + 2;
    localparam int CAPS = 8;

    logic          clk = 1'b0;
    logic          reset_N = 1'b0;
    logic          start_write = 1'b0;
    logic [FW-1:0] frame_num = '0;
    logic          bbox_valid = 1'b0;
    logic          bbox_last = 1'b0;
    logic [BW-1:0] bbox_in = '0;

    always #5 clk = ~clk;

    oflow_bbox_if #(.BBOX_WIDTH(BW)) bb ();
    oflow_bbox_if #(.BBOX_WIDTH(BW)) bbs ();
    oflow_wr_if #(.ADDR_WIDTH(AW),  .BBOX_WIDTH(BW)) wr ();
    oflow_wr_if #(.ADDR_WIDTH(AWS), .BBOX_WIDTH(BW)) wrs ();

    assign bb.bbox_valid  = bbox_valid;
    assign bb.bbox_last   = bbox_last;
    assign bb.bbox_in     = bbox_in;
    assign bbs.bbox_valid = bbox_valid;
    assign bbs.bbox_last  = bbox_last;
    assign bbs.bbox_in    = bbox_in;

    logic [NS-1:0][EPW-1:0]  ep;
    logic [NS-1:0][EPWS-1:0] eps;
    logic [FW-1:0]           cfn, cfns;
    logic                    done, dones, ovf, ovfs;
`ifdef OFLOW_WRITE_DROP_CNT_EN
    logic [EPW-1:0]          drop;
    logic [EPWS-1:0]         drops;
`endif

    oflow_fsm_write #(
        .ADDR_WIDTH(AW), .BBOX_WIDTH(BW), .NUM_SLOTS(NS), .FRAME_NUM_WIDTH(FW)
    ) dut (
        .clk(clk), .reset_N(reset_N), .start_write(start_write), .frame_num(frame_num),
        .bbox(bb), .wr(wr), .end_pointers(ep), .cur_frame_num(cfn),
        .done_write(done), .overflow(ovf)
`ifdef OFLOW_WRITE_DROP_CNT_EN
        , .drop_cnt(drop)
`endif
    );

    oflow_fsm_write #(
        .ADDR_WIDTH(AWS), .BBOX_WIDTH(BW), .NUM_SLOTS(NS), .FRAME_NUM_WIDTH(FW)
    ) dut_small (
        .clk(clk), .reset_N(reset_N), .start_write(start_write), .frame_num(frame_num),
        .bbox(bbs), .wr(wrs), .end_pointers(eps), .cur_frame_num(cfns),
        .done_write(dones), .overflow(ovfs)
`ifdef OFLOW_WRITE_DROP_CNT_EN
        , .drop_cnt(drops)
`endif
    );

    int checks = 0;
    int failures = 0;
    int exp_slot = 0;

    // Write-port monitor for the full-size instance, plus pulse counters.
    logic [AW-1:0] q_addr[$];
    logic          q_off[$];
    logic [2:0]    q_slot[$];
    logic [BW-1:0] q_data[$];
    int            nwrs = 0;
    int            ndone = 0;

    always @(negedge clk) begin
        if (wr.we === 1'b1) begin
            q_addr.push_back(wr.wr_addr);
            q_off.push_back(wr.wr_offset);
            q_slot.push_back(wr.wr_slot);
            q_data.push_back(wr.wr_data);
        end
        if (wrs.we === 1'b1) nwrs++;
        if (done === 1'b1) ndone++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] mkdata(input int fn, input int i);
        return 64'hB0B0_0000_0000_0000 | (64'(fn) << 16) | 64'(i);
    endfunction

    // One frame: start pulse, n bboxes (optionally gappy / with a stray start),
    // then checks on the write log, done pulse, end pointers and slot.
    task automatic run_frame(input int fn, input int n, input bit gaps,
                             input bit pre_valid, input bit mid_start);
        int  i, cyc, base, base_s, base_d, nexp_s;
        bit  acc;
        base   = q_addr.size();
        base_s = nwrs;
        base_d = ndone;
        start_write = 1'b1;
        frame_num   = FW'(fn);
        if (pre_valid) begin
            bbox_valid = 1'b1;
            bbox_last  = 1'b0;
            bbox_in    = mkdata(fn, 0);
        end
        step();
        start_write = 1'b0;
        chk("ready_after_start", 64'(bb.bbox_ready), 64'(1));
        chk("no_we_on_start",    64'(wr.we),         64'(0));
        chk("ep_cleared",        64'(ep[exp_slot]),  64'(0));
        chk("cur_frame_num",     64'(cfn),           64'(fn));
        chk("ovf_small_cleared", 64'(ovfs),          64'(0));
        i = 0;
        cyc = 0;
        while (i < n && cyc < 400) begin
            bbox_valid  = gaps ? (cyc % 3 != 2) : 1'b1;
            bbox_last   = (i == n - 1);
            bbox_in     = mkdata(fn, i);
            start_write = mid_start && (i == 1);
            frame_num   = FW'(fn + 100);
            acc = bbox_valid && bb.bbox_ready;
            step();
            if (acc) i++;
            cyc++;
        end
        bbox_valid  = 1'b0;
        bbox_last   = 1'b0;
        start_write = 1'b0;
        chk("frame_accepts", 64'(i), 64'(n));
        chk("done_pulse",    64'(done), 64'(1));
        chk("ready_drop",    64'(bb.bbox_ready), 64'(0));
        step();
        chk("done_count",    64'(ndone - base_d), 64'(1));
        chk("done_low",      64'(done), 64'(0));
        nexp_s = (n > CAPS) ? CAPS : n;
        chk("we_count",       64'(q_addr.size() - base), 64'(n));
        chk("we_count_small", 64'(nwrs - base_s),        64'(nexp_s));
        for (int j = 0; j < n; j++) begin
            if (base + j < q_addr.size()) begin
                chk("wr_addr",   64'(q_addr[base + j]), 64'(j >> 1));
                chk("wr_offset", 64'(q_off[base + j]),  64'(j & 1));
                chk("wr_slot",   64'(q_slot[base + j]), 64'(exp_slot));
                chk("wr_data",   q_data[base + j],      mkdata(fn, j));
            end
        end
        chk("end_ptr",       64'(ep[exp_slot]),  64'(n));
        chk("end_ptr_small", 64'(eps[exp_slot]), 64'(nexp_s));
        chk("ovf",           64'(ovf),           64'(0));
        chk("ovf_small",     64'(ovfs),          64'(n > CAPS));
`ifdef OFLOW_WRITE_DROP_CNT_EN
        chk("drop_cnt",       64'(drop),  64'(0));
        chk("drop_cnt_small", 64'(drops), 64'((n > CAPS) ? n - CAPS : 0));
`endif
        chk("cfn_held", 64'(cfn), 64'(fn));
        exp_slot = (exp_slot + 1) % NS;
        chk("slot_adv", 64'(wr.wr_slot), 64'(exp_slot));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int wrap_n[6];
        int base;
        wrap_n = '{3, 9, 5, 1, 2, 4};

        // Reset state, with inputs active during reset.
        start_write = 1'b1;
        bbox_valid  = 1'b1;
        #12;
        chk("rst_ready",   64'(bb.bbox_ready), 64'(0));
        chk("rst_we",      64'(wr.we),         64'(0));
        chk("rst_slot",    64'(wr.wr_slot),    64'(0));
        chk("rst_addr",    64'(wr.wr_addr),    64'(0));
        chk("rst_data",    wr.wr_data,         64'(0));
        chk("rst_ep",      64'(ep),            64'(0));
        chk("rst_cfn",     64'(cfn),           64'(0));
        chk("rst_done",    64'(done),          64'(0));
        chk("rst_ovf",     64'(ovf),           64'(0));
        start_write = 1'b0;
        bbox_valid  = 1'b0;
        step();
        reset_N = 1'b1;
        step();

        // Five back-to-back bboxes into slot 0.
        run_frame(12, 5, 1'b0, 1'b0, 1'b0);

        // bbox_valid in IDLE is not accepted.
        base = q_addr.size();
        bbox_valid = 1'b1;
        bbox_in    = 64'hDEAD;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_ready", 64'(bb.bbox_ready), 64'(0));
            chk("idle_we",    64'(wr.we),         64'(0));
        end
        chk("idle_no_writes", 64'(q_addr.size() - base), 64'(0));

        // valid held through start, gaps, stray start during WRITE (slot 1).
        run_frame(33, 6, 1'b1, 1'b1, 1'b1);

        // Overflow on the small instance (slot 2), then recovery (slot 3).
        run_frame(40, 10, 1'b0, 1'b0, 1'b0);
        run_frame(41, 2, 1'b0, 1'b0, 1'b0);

        // Mid-frame reset after three bboxes (slot 4).
        start_write = 1'b1;
        frame_num   = 8'd77;
        step();
        start_write = 1'b0;
        bbox_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bbox_in = mkdata(77, k);
            step();
        end
        bbox_valid = 1'b0;
        #2;
        reset_N = 1'b0;
        #1;
        chk("mrst_ready", 64'(bb.bbox_ready), 64'(0));
        chk("mrst_we",    64'(wr.we),         64'(0));
        chk("mrst_ep",    64'(ep),            64'(0));
        chk("mrst_slot",  64'(wr.wr_slot),    64'(0));
        chk("mrst_cfn",   64'(cfn),           64'(0));
        chk("mrst_addr",  64'(wr.wr_addr),    64'(0));
        chk("mrst_done",  64'(done),          64'(0));
        chk("mrst_ovf",   64'(ovfs),          64'(0));
        step();
        reset_N  = 1'b1;
        exp_slot = 0;
        step();

        // Six frames across the wrap: slots 0,1,2,3,4,0.
        for (int f = 0; f < 6; f++)
            run_frame(20 + f, wrap_n[f], 1'b0, 1'b0, 1'b0);
        chk("wrap_ep1", 64'(ep[1]), 64'(9));
        chk("wrap_ep2", 64'(ep[2]), 64'(5));
        chk("wrap_ep3", 64'(ep[3]), 64'(1));
        chk("wrap_ep4", 64'(ep[4]), 64'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
